regfile_writeback_ctrl: RTL
===========================

// Module: regfile_writeback_ctrl
// PURPOSE
//   Write-side driver for the 32x32 register file. Accepts ALU and load results
//   over valid/ready handshakes and drives the register file's two write ports
//   (address_alu/write_data_alu and address_mem/write_data_mem) one result per
//   port per cycle. Load results are queued so the mem port can be stalled.
//   Enforces WAW ordering and key-gated writes to the secure register window.
// PARAMETERS
//   XLEN    32       data width
//   DEPTH   4        load queue entries (power of 2, >=2)
//   SEC_LO  28       lowest secure register index
//   SEC_HI  31       highest secure register index
//   KEY     16'h0032 key required for secure-window writes
// PORTS
//   clk             in   1     clock, rising edge
//   rst             in   1     synchronous reset, active-high
//   alu_valid       in   1     ALU result offered
//   alu_ready       out  1     ALU result accepted when valid&ready
//   alu_rd          in   5     ALU destination register
//   alu_data        in   XLEN  ALU result
//   load_valid      in   1     load result offered
//   load_ready      out  1     load result accepted when valid&ready
//   load_rd         in   5     load destination register
//   load_data       in   XLEN  load result
//   mem_port_stall  in   1     hold load queue; mem write port idles
//   key_in          in   16    key presented with current results
//   address_alu     out  5     ALU write port address
//   write_data_alu  out  XLEN  ALU write port data
//   address_mem     out  5     mem write port address
//   write_data_mem  out  XLEN  mem write port data
//   key_fault       out  1     1-cycle pulse: secure write blocked
//   fault_count     out  8     blocked secure writes, saturating at 255
//   queue_level     out  3     load queue occupancy 0..DEPTH
// BEHAVIOUR
//   - Idle write port = address 0, data 0 (writing 0 to x0 is harmless).
//   - Reset: all outputs 0, queue empty, counters 0, alu_ready=load_ready=0
//     while rst=1. Reset mid-operation discards queued loads without writing.
//   - ALU path: alu_ready=1 whenever rst=0. Accepted at edge k -> driven on
//     address_alu/write_data_alu for exactly the cycle after edge k (latency 1);
//     idle afterwards unless another result was accepted.
//   - Load path: load_ready = !full. Queue is FIFO in acceptance order. Each
//     cycle with mem_port_stall=0 the head is popped into the mem output reg
//     (driven next cycle); stall=1 -> output reg idle, queue holds. Empty queue,
//     no stall: accepted load bypasses queue, latency 1. Full and popping in the
//     same cycle still reports full (no same-cycle refill).
//   - WAW: an accepted ALU result is always newer than every queued/accepted
//     load. On ALU accept with rd!=0, every queued entry (and the same-cycle
//     load) with equal rd is invalidated; invalid entries pop without a write
//     (port idle that cycle) and still occupy a slot until popped.
//   - Secure window SEC_LO..SEC_HI: write issued only if key_in==KEY in the
//     acceptance cycle (key sampled at accept, stored with entry). Otherwise
//     entry accepted/consumed, port idles, key_fault pulses the cycle after
//     accept; two faults in one cycle add 2 to fault_count (saturating) and
//     pulse key_fault once.
//   - rd==0 accepted and consumed, never written, never a fault.
//   - Both ports never carry the same nonzero address in the same cycle
//     (guaranteed by WAW invalidation).
// TESTING
//   - Reset: rst=1 2 cycles mid-traffic -> all outputs 0, queue_level=0, readies 0.
//   - ALU x5=0xDEADBEEF at edge k -> address_alu=5, data=0xDEADBEEF cycle after k, then 0.
//   - stall=1, push 5 loads (x1..x5) -> 4 accepted, load_ready=0, level=4;
//     release -> x1..x4 written in order, one per cycle.
//   - WAW: queue holds x7=0x11 (stalled), ALU x7=0x22 -> ALU writes 0x22;
//     queued x7 pops with no write, x7 final value 0x22.
//   - Secure: ALU x30 key_in=0x0000 -> no write, key_fault pulse, fault_count=1;
//     key_in=0x0032 -> x30 written.
//   - Saturation: 260 blocked secure writes -> fault_count=255, holds.

Source files
------------

// File: rtl/regfile_writeback_ctrl_if.sv
// regfile_writeback_ctrl_if: result handshakes and register-file write ports of the writeback controller
interface regfile_writeback_ctrl_if #(parameter int XLEN = 32);
    logic            alu_valid, alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            load_valid, load_ready;
    logic [4:0]      load_rd;
    logic [XLEN-1:0] load_data;
    logic            mem_port_stall;
    logic [15:0]     key_in;
    logic [4:0]      address_alu, address_mem;
    logic [XLEN-1:0] write_data_alu, write_data_mem;
    logic            key_fault;
    logic [7:0]      fault_count;
    logic [2:0]      queue_level;
    modport master(
        output alu_valid, alu_rd, alu_data, load_valid, load_rd, load_data, mem_port_stall, key_in,
        input  alu_ready, load_ready, address_alu, write_data_alu, address_mem, write_data_mem,
               key_fault, fault_count, queue_level
    );
    modport slave(
        input  alu_valid, alu_rd, alu_data, load_valid, load_rd, load_data, mem_port_stall, key_in,
        output alu_ready, load_ready, address_alu, write_data_alu, address_mem, write_data_mem,
               key_fault, fault_count, queue_level
    );
endinterface

// File: rtl/regfile_writeback_ctrl.sv
// regfile_writeback_ctrl: drives the two register-file write ports from ALU and queued load results
module regfile_writeback_ctrl #(
    parameter int          XLEN   = 32,
    parameter int          DEPTH  = 4,
    parameter int          SEC_LO = 28,
    parameter int          SEC_HI = 31,
    parameter logic [15:0] KEY    = 16'h0032
) (
    input logic clk,
    input logic rst,
    regfile_writeback_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [4:0] LO = 5'(SEC_LO);
    localparam logic [4:0] HI = 5'(SEC_HI);
    typedef struct packed {
        logic            we;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;
    entry_t [DEPTH-1:0] fifo_q, fifo_d;
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [AW:0] count_q, count_d;
    logic [4:0] addr_alu_q, addr_alu_d, addr_mem_q, addr_mem_d;
    logic [XLEN-1:0] data_alu_q, data_alu_d, data_mem_q, data_mem_d;
    logic key_fault_q, key_fault_d;
    logic [7:0] fault_count_q, fault_count_d;
    logic alu_fire, load_fire, key_ok, alu_sec, load_sec, kill, pop, bypass, push;
    logic [1:0] faults;
    logic [8:0] fault_sum;
    entry_t new_ent, out_ent;
    assign bus.alu_ready      = !rst;
    assign bus.load_ready     = !rst && count_q != FULL;
    assign bus.address_alu    = addr_alu_q;
    assign bus.write_data_alu = data_alu_q;
    assign bus.address_mem    = addr_mem_q;
    assign bus.write_data_mem = data_mem_q;
    assign bus.key_fault      = key_fault_q;
    assign bus.fault_count    = fault_count_q;
    assign bus.queue_level    = 3'(count_q);
    always_comb begin
        alu_fire  = bus.alu_valid && !rst;
        load_fire = bus.load_valid && bus.load_ready;
        key_ok    = bus.key_in == KEY;
        alu_sec   = bus.alu_rd != 5'd0 && bus.alu_rd >= LO && bus.alu_rd <= HI;
        load_sec  = bus.load_rd != 5'd0 && bus.load_rd >= LO && bus.load_rd <= HI;
        kill      = alu_fire && bus.alu_rd != 5'd0;
        new_ent   = '{we: bus.load_rd != 5'd0 && (key_ok || !load_sec) && !(kill && bus.alu_rd == bus.load_rd),
                      rd: bus.load_rd, data: bus.load_data};
        // the ALU result is newest, so any older load to the same register must never land
        fifo_d = fifo_q;
        for (int i = 0; i < DEPTH; i++)
            if (kill && fifo_q[i].rd == bus.alu_rd) fifo_d[i].we = 1'b0;
        pop     = !bus.mem_port_stall && count_q != '0;
        bypass  = !bus.mem_port_stall && count_q == '0 && load_fire;
        push    = load_fire && !bypass;
        out_ent = pop ? fifo_d[rptr_q] : bypass ? new_ent : '0;
        if (push) fifo_d[wptr_q] = new_ent;
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        addr_mem_d = out_ent.we ? out_ent.rd : '0;
        data_mem_d = out_ent.we ? out_ent.data : '0;
        addr_alu_d = kill && (key_ok || !alu_sec) ? bus.alu_rd : '0;
        data_alu_d = kill && (key_ok || !alu_sec) ? bus.alu_data : '0;
        faults = 2'(alu_fire && alu_sec && !key_ok) + 2'(load_fire && load_sec && !key_ok);
        fault_sum = {1'b0, fault_count_q} + 9'(faults);
        fault_count_d = fault_sum[8] ? 8'hFF : fault_sum[7:0];
        key_fault_d = faults != 2'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q        <= '0;
            rptr_q        <= '0;
            wptr_q        <= '0;
            count_q       <= '0;
            addr_alu_q    <= '0;
            data_alu_q    <= '0;
            addr_mem_q    <= '0;
            data_mem_q    <= '0;
            key_fault_q   <= 1'b0;
            fault_count_q <= '0;
        end else begin
            fifo_q        <= fifo_d;
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
            count_q       <= count_d;
            addr_alu_q    <= addr_alu_d;
            data_alu_q    <= data_alu_d;
            addr_mem_q    <= addr_mem_d;
            data_mem_q    <= data_mem_d;
            key_fault_q   <= key_fault_d;
            fault_count_q <= fault_count_d;
        end
    end
endmodule
